inner_prod_engine: RTL and testbench

INNER_PROD_ENGINE -- requirements
Module: inner_prod_engine

---
 rtl/inner_prod_engine_pkg.sv | 46 ++++
 rtl/inner_prod_engine_axil_regs.sv | 143 ++++++++++++++
 rtl/inner_prod_engine.sv | 89 ++++++++
 tb/tb_inner_prod_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inner_prod_engine_pkg.sv
// Shared definitions for inner_prod_engine: register offsets, CTRL bit, AXI response codes,
// FSM state enums and the address decoder used by the register block.
package inner_prod_engine_pkg;

    localparam logic [31:0] OFF_COEF0 = 32'h00;
    localparam logic [31:0] OFF_COEF1 = 32'h04;
    localparam logic [31:0] OFF_COEF2 = 32'h08;
    localparam logic [31:0] OFF_COEF3 = 32'h0C;
    localparam logic [31:0] OFF_CTRL  = 32'h10;
    localparam logic [31:0] OFF_CNT   = 32'h14;

    localparam int unsigned CTRL_EN_BIT = 0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wr_state_e;
    typedef enum logic { R_IDLE, R_RESP } rd_state_e;

    // SEL_COEF0..3 encode the coefficient index in their low two bits.
    typedef enum logic [2:0] {
        SEL_COEF0 = 3'd0,
        SEL_COEF1 = 3'd1,
        SEL_COEF2 = 3'd2,
        SEL_COEF3 = 3'd3,
        SEL_CTRL  = 3'd4,
        SEL_CNT   = 3'd5,
        SEL_NONE  = 3'd7
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        case (addr)
            OFF_COEF0: sel = SEL_COEF0;
            OFF_COEF1: sel = SEL_COEF1;
            OFF_COEF2: sel = SEL_COEF2;
            OFF_COEF3: sel = SEL_COEF3;
            OFF_CTRL:  sel = SEL_CTRL;
            OFF_CNT:   sel = SEL_CNT;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/inner_prod_engine_axil_regs.sv
// AXI4-Lite slave for inner_prod_engine: write/read FSMs and COEF/CTRL register file.
// INNER_PROD_ENGINE_CNT_EN adds the result counter readable at the CNT offset.
module inner_prod_engine_axil_regs
    import inner_prod_engine_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 8
) (
    input  logic               clk,
    input  logic               sync_rst_n,
`ifdef INNER_PROD_ENGINE_CNT_EN
    input  logic               result_pulse,
`endif
    input  logic [AW-1:0]      s_axi_awaddr,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [DW-1:0]      s_axi_wdata,
    input  logic [DW/8-1:0]    s_axi_wstrb,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    output logic [1:0]         s_axi_bresp,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    input  logic [AW-1:0]      s_axi_araddr,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    output logic [DW-1:0]      s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready,
    output logic [3:0][DW-1:0] coef,
    output logic               en
);

    wr_state_e     wr_state, wr_next;
    rd_state_e     rd_state, rd_next;
    reg_sel_e      wr_sel, rd_sel;
    logic          wr_fire, rd_fire, wr_ok, rd_ok;
    logic [DW-1:0] rd_word;

    assign wr_sel = decode_addr(32'(s_axi_awaddr));
    assign rd_sel = decode_addr(32'(s_axi_araddr));
    assign wr_ok  = (wr_sel != SEL_NONE) && (wr_sel != SEL_CNT);

    // Address and data are only taken together, so one ready term covers both channels.
    always_comb begin
        wr_next       = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (sync_rst_n && s_axi_awvalid && s_axi_wvalid) begin
                    s_axi_awready = 1'b1;
                    s_axi_wready  = 1'b1;
                    wr_next       = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wr_next = W_IDLE;
            end
        endcase
    end

    assign wr_fire = s_axi_awready;

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            wr_state    <= W_IDLE;
            s_axi_bresp <= RESP_OKAY;
            coef        <= '0;
            en          <= 1'b1;
        end else begin
            wr_state <= wr_next;
            if (wr_fire) begin
                s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_sel inside {SEL_COEF0, SEL_COEF1, SEL_COEF2, SEL_COEF3}) begin
                    for (int unsigned b = 0; b < DW/8; b++) begin
                        if (s_axi_wstrb[b]) coef[wr_sel[1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                    end
                end
                if (wr_sel == SEL_CTRL && s_axi_wstrb[0]) en <= s_axi_wdata[CTRL_EN_BIT];
            end
        end
    end

`ifdef INNER_PROD_ENGINE_CNT_EN
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!sync_rst_n)       cnt <= '0;
        else if (result_pulse) cnt <= cnt + DW'(1);
    end
`endif

    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b1;
        case (rd_sel)
            SEL_COEF0, SEL_COEF1, SEL_COEF2, SEL_COEF3: rd_word = coef[rd_sel[1:0]];
            SEL_CTRL: rd_word[CTRL_EN_BIT] = en;
`ifdef INNER_PROD_ENGINE_CNT_EN
            SEL_CNT:  rd_word = cnt;
`endif
            default:  rd_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_next       = rd_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_axi_arready = sync_rst_n;
                if (sync_rst_n && s_axi_arvalid) rd_next = R_RESP;
            end
            R_RESP: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) rd_next = R_IDLE;
            end
        endcase
    end

    assign rd_fire = s_axi_arready && s_axi_arvalid;

    // Read data is captured at the accept edge, before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            rd_state    <= R_IDLE;
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (rd_fire) begin
                s_axi_rdata <= rd_word;
                s_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: rtl/inner_prod_engine.sv
// 4-element inner-product engine: two-stage multiply/sum pipeline with AXI4-Lite coefficients.
// Define INNER_PROD_ENGINE_CNT_EN to include the result counter register.
module inner_prod_engine
    import inner_prod_engine_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 8
) (
    input  logic               clk,
    input  logic               sync_rst_n,
    input  logic [3:0][DW-1:0] input_vec,
    input  logic               input_vec_valid,
    output logic [DW-1:0]      inner_prod,
    output logic               inner_prod_valid,
    input  logic [AW-1:0]      s_axi_awaddr,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [DW-1:0]      s_axi_wdata,
    input  logic [DW/8-1:0]    s_axi_wstrb,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    output logic [1:0]         s_axi_bresp,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    input  logic [AW-1:0]      s_axi_araddr,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    output logic [DW-1:0]      s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready
);

    logic [3:0][DW-1:0] coef;
    logic [3:0][DW-1:0] prod;
    logic               en;
    logic               stage1_valid;
    logic               take;

    inner_prod_engine_axil_regs #(
        .DW(DW),
        .AW(AW)
    ) u_regs (
        .clk           (clk),
        .sync_rst_n    (sync_rst_n),
`ifdef INNER_PROD_ENGINE_CNT_EN
        .result_pulse  (inner_prod_valid),
`endif
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .coef          (coef),
        .en            (en)
    );

    assign take = input_vec_valid && en;

    // Only the low DW bits of each product matter for a sum that wraps at DW bits.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            prod             <= '0;
            stage1_valid     <= 1'b0;
            inner_prod       <= '0;
            inner_prod_valid <= 1'b0;
        end else begin
            stage1_valid <= take;
            if (take) begin
                for (int unsigned i = 0; i < 4; i++) prod[i] <= coef[i] * input_vec[i];
            end
            inner_prod_valid <= stage1_valid;
            if (stage1_valid) inner_prod <= prod[0] + prod[1] + prod[2] + prod[3];
        end
    end

endmodule

// File: tb/tb_inner_prod_engine.sv
// Self-checking bench for inner_prod_engine: directed vectors against a register-image and
// result-schedule model; honours INNER_PROD_ENGINE_CNT_EN for the CNT expectations.
module tb_inner_prod_engine;

    logic              clk = 1'b0;
    logic              sync_rst_n = 1'b0;
    logic [3:0][31:0]  input_vec = '0;
    logic              input_vec_valid = 1'b0;
    logic [31:0]       inner_prod;
    logic              inner_prod_valid;
    logic [7:0]        awaddr = '0, araddr = '0;
    logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [31:0]       rdata;

    inner_prod_engine #(.DW(32), .AW(8)) dut (
        .clk(clk), .sync_rst_n(sync_rst_n),
        .input_vec(input_vec), .input_vec_valid(input_vec_valid),
        .inner_prod(inner_prod), .inner_prod_valid(inner_prod_valid),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] m_coef [4];
    logic        m_en;
    int          m_cnt;
    logic [31:0] m_last;
    logic [31:0] sched [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_dot(input logic [3:0][31:0] v);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 4; i++) s = s + m_coef[i] * v[i];
        return s;
    endfunction

    function automatic logic [1:0] model_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a == 8'h00 || a == 8'h04 || a == 8'h08 || a == 8'h0C) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_coef[a / 4][8*b +: 8] = d[8*b +: 8];
            return 2'b00;
        end
        if (a == 8'h10) begin
            if (s[0]) m_en = d[0];
            return 2'b00;
        end
        return 2'b10;
    endfunction

    task automatic model_rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        d = 32'd0;
        r = 2'b00;
        if (a == 8'h00 || a == 8'h04 || a == 8'h08 || a == 8'h0C) d = m_coef[a / 4];
        else if (a == 8'h10) d = {31'd0, m_en};
`ifdef INNER_PROD_ENGINE_CNT_EN
        else if (a == 8'h14) d = 32'(m_cnt);
`endif
        else r = 2'b10;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_coef[i] = 32'd0;
        m_en = 1'b1;
    endtask

    // Per-cycle output check: a result is due exactly when the model scheduled one.
    initial begin
        m_last = 32'd0;
        m_cnt  = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!sync_rst_n) begin
                m_last = 32'd0;
                m_cnt  = 0;
                sched.delete();
            end
            @(negedge clk);
            if (sched.exists(cyc)) begin
                chk("out_valid", {63'd0, inner_prod_valid}, 64'd1);
                chk("out_value", {32'd0, inner_prod}, {32'd0, sched[cyc]});
                m_last = sched[cyc];
                m_cnt++;
                sched.delete(cyc);
            end else begin
                chk("out_idle_valid", {63'd0, inner_prod_valid}, 64'd0);
                chk("out_hold", {32'd0, inner_prod}, {32'd0, m_last});
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        input_vec       = {d, c, b, a};
        input_vec_valid = 1'b1;
        if (m_en) sched[cyc + 2] = model_dot(input_vec);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        input_vec_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] er;
        int n;
        er = model_wr(a, d, s);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        chk("wr_accept", {62'd0, awready, wready}, 64'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk("wr_bvalid", {63'd0, bvalid}, 64'd1);
        chk("wr_bresp", {62'd0, bresp}, {62'd0, er});
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
        logic [31:0] ed;
        logic [1:0]  er;
        int n;
        model_rd(a, ed, er);
        araddr = a; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk("rd_accept", {63'd0, arready}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        chk("rd_rvalid", {63'd0, rvalid}, 64'd1);
        chk("rd_rdata", {32'd0, rdata}, {32'd0, ed});
        chk("rd_rresp", {62'd0, rresp}, {62'd0, er});
        d = rdata;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] pre;
        int k;
        model_reset();

        // Reset with requests pending: nothing may be accepted or driven.
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inner_prod", {32'd0, inner_prod}, 64'd0);
        chk("rst_valid", {63'd0, inner_prod_valid}, 64'd0);
        chk("rst_ready", {61'd0, awready, wready, arready}, 64'd0);
        chk("rst_bvalid_rvalid", {62'd0, bvalid, rvalid}, 64'd0);
        chk("rst_resp", {60'd0, bresp, rresp}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        sync_rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_bvalid_rvalid", {62'd0, bvalid, rvalid}, 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) axi_read(8'(4 * i), rd);
        axi_read(8'h10, rd);
        chk("ctrl_reset_en", {32'd0, rd}, 64'd1);

        // COEF=1,2,3,4 with all-ones input gives 10, two cycles after the sample.
        axi_write(8'h00, 32'd1, 4'hF);
        axi_write(8'h04, 32'd2, 4'hF);
        axi_write(8'h08, 32'd3, 4'hF);
        axi_write(8'h0C, 32'd4, 4'hF);
        k = cyc;
        send(1, 1, 1, 1);
        idle(0);
        while (cyc < k + 2) @(negedge clk);
        chk("lit_dot10", {32'd0, inner_prod}, 64'd10);
        chk("lit_dot10_valid", {63'd0, inner_prod_valid}, 64'd1);
        @(posedge clk); #1;
        idle(3);

        // Back-to-back inputs.
        send(32'd7, 32'd0, 32'd1, 32'd2);
        send(32'hFFFF_FFFF, 32'd5, 32'd6, 32'd100);
        send(32'd1000, 32'd2000, 32'd3000, 32'd4000);
        send(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h8000_0001);
        idle(4);

        // Signed wrap cases.
        axi_write(8'h00, 32'hFFFF_FFFF, 4'hF);
        axi_write(8'h04, 32'd0, 4'hF);
        axi_write(8'h08, 32'd0, 4'hF);
        axi_write(8'h0C, 32'd0, 4'hF);
        k = cyc;
        send(5, 0, 0, 0);
        idle(0);
        while (cyc < k + 2) @(negedge clk);
        chk("lit_neg5", {32'd0, inner_prod}, 64'hFFFF_FFFB);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) axi_write(8'(4 * i), 32'h8000_0000, 4'hF);
        k = cyc;
        send(2, 2, 2, 2);
        idle(0);
        while (cyc < k + 2) @(negedge clk);
        chk("lit_wrap0", {32'd0, inner_prod}, 64'd0);
        chk("lit_wrap0_valid", {63'd0, inner_prod_valid}, 64'd1);
        @(posedge clk); #1;
        idle(3);

        // Byte strobes.
        axi_write(8'h04, 32'hAABB_CCDD, 4'hF);
        axi_write(8'h04, 32'h1122_3344, 4'b0101);
        axi_read(8'h04, rd);
        chk("lit_wstrb", {32'd0, rd}, 64'hAA22_CC44);

        // Error responses, ignored writes, CNT visibility.
        axi_read(8'h18, rd);
        axi_read(8'h02, rd);
        axi_write(8'h18, 32'hDEAD_BEEF, 4'hF);
        axi_write(8'h05, 32'hDEAD_BEEF, 4'hF);
        axi_write(8'h14, 32'hDEAD_BEEF, 4'hF);
        axi_read(8'h04, rd);
        axi_read(8'h14, rd);
`ifdef INNER_PROD_ENGINE_CNT_EN
        chk("lit_cnt7", {32'd0, rd}, 64'd7);
`endif

        // Address and data arriving separately, then a stalled response.
        pre = model_wr(8'h08, 32'h0000_0042, 4'hF);
        chk("lit_okay_model", {62'd0, pre[1:0]}, 64'd0);
        awaddr = 8'h08; wdata = 32'h0000_0042; wstrb = 4'hF; awvalid = 1'b1; bready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("aw_alone_ready", {62'd0, awready, wready}, 64'd0);
            @(posedge clk); #1;
        end
        wvalid = 1'b1;
        @(negedge clk);
        chk("joint_ready", {62'd0, awready, wready}, 64'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bvalid_held", {63'd0, bvalid}, 64'd1);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(negedge clk);
        chk("bvalid_final", {61'd0, bvalid, bresp}, 64'd4);
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk("bvalid_dropped", {63'd0, bvalid}, 64'd0);
        @(posedge clk); #1;
        axi_read(8'h08, rd);

        // Same-cycle read and write of COEF2: read sees the old value.
        pre = m_coef[2];
        awaddr = 8'h08; wdata = 32'h0000_0066; wstrb = 4'hF; araddr = 8'h08;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        chk("simul_ready", {61'd0, awready, wready, arready}, 64'd7);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("simul_valids", {62'd0, bvalid, rvalid}, 64'd3);
        chk("simul_rdata_old", {32'd0, rdata}, {32'd0, pre});
        chk("lit_simul_old", {32'd0, rdata}, 64'h42);
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        void'(model_wr(8'h08, 32'h0000_0066, 4'hF));
        axi_read(8'h08, rd);

        // EN cleared: valid inputs are dropped.
        axi_write(8'h10, 32'd0, 4'hF);
        axi_read(8'h10, rd);
        send(1, 2, 3, 4);
        send(5, 6, 7, 8);
        send(9, 10, 11, 12);
        send(13, 14, 15, 16);
        idle(4);
        axi_write(8'h10, 32'hFFFF_FFFF, 4'hF);
        axi_read(8'h10, rd);
        send(3, 1, 4, 1);
        idle(4);

        // Reset while a write response is pending.
        awaddr = 8'h00; wdata = 32'h0000_1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        axi_write(8'h10, 32'd0, 4'h0);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'h00; bready = 1'b0;
        @(negedge clk);
        chk("rst_test_accept", {62'd0, awready, wready}, 64'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("rst_test_bvalid_pre", {63'd0, bvalid}, 64'd1);
        @(posedge clk); #1;
        sync_rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_bvalid", {63'd0, bvalid}, 64'd0);
        sync_rst_n = 1'b1;
        model_reset();
        bready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_bvalid", {62'd0, bvalid, rvalid}, 64'd0);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(8'h00, rd);
        chk("lit_rst_coef0", {32'd0, rd}, 64'd0);
        axi_read(8'h10, rd);
        chk("lit_rst_en", {32'd0, rd}, 64'd1);
        for (int i = 1; i < 4; i++) axi_read(8'(4 * i), rd);
        axi_read(8'h14, rd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
